// File: rtl/tx_ser_pkg.sv
// Shared types and constants for the tx_ser byte serializer.
package tx_ser_pkg;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_START = 7'b000_0010,
        S_BIT   = 7'b000_0100,
        S_STOP  = 7'b000_1000,
        S_CRC_L = 7'b001_0000,
        S_CRC_H = 7'b010_0000,
        S_BREAK = 7'b100_0000
    } state_e;

    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CRC_POLY   = 16'hA001;
    localparam int unsigned BREAK_BITS = 10;

    // Frame bit indices: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0]  LAST_DATA_IDX = 4'd8;
    localparam logic [3:0]  STOP_IDX      = 4'd9;
    localparam logic [3:0]  BRK_HIGH_IDX  = 4'(BREAK_BITS);
    localparam logic [10:0] BREAK_PAT     = 11'(1) << BREAK_BITS;

    // Line pattern for one frame, shifted out from bit 0; spare top bit idles high.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {2'b11, b, 1'b0};
    endfunction

endpackage

// File: rtl/serial_crc.sv
// Bit-serial CRC-16/MODBUS (reflected) accumulator with synchronous clear.
module serial_crc
    import tx_ser_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clean,
    input  logic        data_clk,
    input  logic        data_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        fb    = crc_q[0] ^ data_in;
        crc_d = crc_q;
        if (clean) begin
            crc_d = CRC_INIT;
        end else if (data_clk) begin
            crc_d = (crc_q >> 1) ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_ser.sv
// Byte serializer: UART-style frames, low-speed first frame, CRC-16 trailer, break.
//   state   | meaning
//   IDLE    | line high, driver off, CRC held at init
//   START   | start bit (0)
//   BIT     | 8 payload data bits, LSB first, fed to CRC
//   STOP    | stop bit (1); holds here between bytes while no data
//   CRC_L   | full frame carrying CRC low byte
//   CRC_H   | full frame carrying CRC high byte, then done
//   BREAK   | 10 low bits then 1 high bit at low-speed divisor
module tx_ser
    import tx_ser_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] div_ls,
    input  logic [15:0] div_hs,
    input  logic        tx_permit,
    input  logic        abort,
    input  logic        send_break,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        tx_en,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [10:0] sh_q, sh_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        last_q, last_d;
    logic        tx_q, tx_d;
    logic        tx_en_q, tx_en_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        crc_feed;
    logic [15:0] crc;

    assign bit_end  = (cnt_q == 16'd0);
    assign crc_feed = (state_q == S_BIT) && bit_end && !abort;

    assign in_ready = in_valid && !abort &&
                      (((state_q == S_IDLE) && tx_permit && !send_break) ||
                       ((state_q == S_STOP) && bit_end && !last_q));

    serial_crc u_crc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clean    (state_q == S_IDLE),
        .data_clk (crc_feed),
        .data_in  (sh_q[0]),
        .crc      (crc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            sh_q    <= '1;
            idx_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            last_q  <= 1'b0;
            tx_q    <= 1'b1;
            tx_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            tx_en_q <= tx_en_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (send_break) begin
                    state_d = S_BREAK;
                end else if (in_valid && tx_permit) begin
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) state_d = S_BIT;
            S_BIT:   if (bit_end && idx_q == LAST_DATA_IDX) state_d = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (last_q) begin
                        state_d = S_CRC_L;
                    end else if (in_valid) begin
                        state_d = S_START;
                    end
                end
            end
            S_CRC_L: if (bit_end && idx_q == STOP_IDX) state_d = S_CRC_H;
            S_CRC_H: if (bit_end && idx_q == STOP_IDX) state_d = S_IDLE;
            S_BREAK: if (bit_end && idx_q == BRK_HIGH_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Datapath and registered outputs; tx always follows bit 0 of the shifter.
    always_comb begin
        sh_d   = sh_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        div_d  = div_q;
        last_d = last_q;
        done_d = 1'b0;
        if (abort) begin
            sh_d  = '1;
            idx_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sh_d  = '1;
                    idx_d = '0;
                    cnt_d = '0;
                    if (send_break) begin
                        sh_d  = BREAK_PAT;
                        div_d = div_ls;
                        cnt_d = div_ls;
                    end else if (in_ready) begin
                        sh_d   = frame_of(in_data);
                        last_d = in_last;
                        div_d  = div_ls;
                        cnt_d  = div_ls;
                    end
                end
                S_STOP: begin
                    if (!bit_end) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (last_q) begin
                        sh_d  = frame_of(crc[7:0]);
                        idx_d = '0;
                        div_d = div_hs;
                        cnt_d = div_hs;
                    end else if (in_ready) begin
                        sh_d   = frame_of(in_data);
                        last_d = in_last;
                        idx_d  = '0;
                        div_d  = div_hs;
                        cnt_d  = div_hs;
                    end
                end
                default: begin
                    if (!bit_end) begin
                        cnt_d = cnt_q - 16'd1;
                    end else if (state_q == S_CRC_L && state_d == S_CRC_H) begin
                        sh_d  = frame_of(crc[15:8]);
                        idx_d = '0;
                        div_d = div_hs;
                        cnt_d = div_hs;
                    end else if (state_d == S_IDLE) begin
                        sh_d   = '1;
                        idx_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        sh_d  = {1'b1, sh_q[10:1]};
                        idx_d = idx_q + 4'd1;
                        cnt_d = div_q;
                    end
                end
            endcase
        end
        tx_d    = sh_d[0];
        tx_en_d = (state_d != S_IDLE);
    end

    assign tx    = tx_q;
    assign tx_en = tx_en_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_tx_ser.sv
// Scoreboard bench for tx_ser: expected line patterns queued at issue, checked by a line monitor.
module tb_tx_ser;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] div_ls = 16'd9;
    logic [15:0] div_hs = 16'd1;
    logic        tx_permit = 1'b1;
    logic        abort = 1'b0;
    logic        send_break = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, tx, tx_en, busy, done;

    tx_ser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .div_ls     (div_ls),
        .div_hs     (div_hs),
        .tx_permit  (tx_permit),
        .abort      (abort),
        .send_break (send_break),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .tx_en      (tx_en),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] pat;
        int          nbits;
        int          per;
    } item_t;

    item_t q[$];
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b1;
    logic  prev_tx = 1'b1;
    int    done_cnt = 0;
    int    ir_cnt = 0;
    int    ir_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic exp_frame(input logic [7:0] d, input int per);
        item_t it;
        it.pat   = {2'b11, d, 1'b0};
        it.nbits = 10;
        it.per   = per;
        q.push_back(it);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (in_ready === 1'b1) ir_cnt++;
        if (in_ready === 1'b1 && in_valid !== 1'b1) ir_bad++;
    end

    // Line monitor: each falling edge from idle opens the next expected frame.
    initial begin : monitor
        item_t       it;
        logic [10:0] got;
        logic [3:0]  b;
        bit          glitch;
        forever begin
            @(negedge clk);
            if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got start bit at %0t expected none", $time);
                end else begin
                    it     = q.pop_front();
                    got    = '1;
                    glitch = 1'b0;
                    for (int k = 0; k < it.nbits * it.per; k++) begin
                        if (k > 0) @(negedge clk);
                        b = 4'(k / it.per);
                        if (k % it.per == 0) got[b] = tx;
                        if (tx !== it.pat[b]) glitch = 1'b1;
                    end
                    check($sformatf("frame_per%0d", it.per), {20'd0, glitch, got}, {21'd0, it.pat});
                end
            end
            prev_tx = tx;
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last);
        int n;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 3000);
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected handshake for 0x%0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit first, input bit end_pkt,
                            input logic [15:0] crc, input int pls, input int phs);
        bit lst;
        for (int i = 0; i < s.len(); i++) begin
            lst = end_pkt && (i == s.len() - 1);
            exp_frame(s[i], (first && i == 0) ? pls : phs);
            if (lst) begin
                exp_frame(crc[7:0], phs);
                exp_frame(crc[15:8], phs);
            end
            send_byte(s[i], lst);
        end
    endtask

    task automatic finish_pkt(input string name, input int d0);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected pulse", name);
        end
        repeat (5) @(negedge clk);
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_queue_empty"}, 32'(q.size()), 32'd0);
        check({name, "_line_idle"}, 32'({tx, tx_en, busy}), 32'b100);
    endtask

    initial begin
        int d0, i0, bad, n;
        item_t brk;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({tx, tx_en, in_ready, busy, done}), 32'b10000);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", 32'({tx, tx_en, in_ready, busy, done}), 32'b10000);

        // Single byte 0x55 ('U'): CRC-16/MODBUS of 0x55 is 0x7F7F.
        @(posedge clk);
        #1;
        div_ls = 16'd9;
        div_hs = 16'd1;
        d0 = done_cnt;
        send_str("U", 1'b1, 1'b1, 16'h7F7F, 10, 2);
        @(negedge clk);
        check("u_busy", 32'({busy, tx_en}), 32'b11);
        finish_pkt("u", d0);

        // Standard check string, CRC 0x4B37.
        @(posedge clk);
        #1;
        div_ls = 16'd4;
        div_hs = 16'd2;
        d0 = done_cnt;
        send_str("123456789", 1'b1, 1'b1, 16'h4B37, 5, 3);
        finish_pkt("chk", d0);

        // Break at div_ls=3: 40 clk low, 4 clk high.
        @(posedge clk);
        #1;
        div_ls = 16'd3;
        d0 = done_cnt;
        i0 = ir_cnt;
        brk.pat   = 11'b100_0000_0000;
        brk.nbits = 11;
        brk.per   = 4;
        q.push_back(brk);
        send_break = 1'b1;
        @(posedge clk);
        #1 send_break = 1'b0;
        finish_pkt("brk", d0);
        check("brk_no_ready", 32'(ir_cnt - i0), 32'd0);

        // Long inter-byte gap inside a packet.
        @(posedge clk);
        #1;
        div_ls = 16'd4;
        div_hs = 16'd2;
        d0 = done_cnt;
        send_str("12345", 1'b1, 1'b0, 16'h0000, 5, 3);
        repeat (30) @(negedge clk);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_en !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        check("gap_hold_line", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        send_str("6789", 1'b0, 1'b1, 16'h4B37, 5, 3);
        finish_pkt("gap", d0);

        // Abort during the 4th data bit.
        @(posedge clk);
        #1;
        div_ls = 16'd3;
        div_hs = 16'd1;
        mon_en = 1'b0;
        d0 = done_cnt;
        send_byte(8'hF0, 1'b0);
        repeat (17) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("pre_abort_line", 32'({tx, tx_en, in_ready}), 32'b010);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'({tx, tx_en, busy}), 32'b100);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        send_str("U", 1'b1, 1'b1, 16'h7F7F, 4, 2);
        finish_pkt("post_abort", d0);

        // tx_permit gating in IDLE, ignored once the packet runs.
        @(posedge clk);
        #1;
        tx_permit = 1'b0;
        d0 = done_cnt;
        i0 = ir_cnt;
        exp_frame(8'h55, 4);
        exp_frame(8'h7F, 2);
        exp_frame(8'h7F, 2);
        in_data  = 8'h55;
        in_last  = 1'b1;
        in_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("permit_low_ready", 32'(ir_cnt - i0), 32'd0);
        check("permit_low_line", 32'(bad), 32'd0);
        @(posedge clk);
        #1 tx_permit = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (in_ready !== 1'b1 && n < 10);
        check("permit_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tx_permit = 1'b0;
        @(negedge clk);
        check("permit_start_edge", 32'({tx, tx_en}), 32'b01);
        finish_pkt("permit", d0);
        tx_permit = 1'b1;

        check("ready_without_valid", 32'(ir_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
